multichannel_delay_engine: RTL and testbench

MULTICHANNEL_DELAY_ENGINE -- requirements
Module: multichannel_delay_engine

---
 rtl/multichannel_delay_engine.sv | 202 ++++++++++++++++++++
 tb/tb_multichannel_delay_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_delay_engine.sv
// Multichannel delay line: one shared synchronous RAM, per-channel regions, a shared write pointer,
// feedforward / feedback / ping-pong write paths, a freeze loop and a dry/wet output mix.
module multichannel_delay_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int FB_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] audio_in,
    output logic                         ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] audio_out,
    output logic                         audio_out_valid,
    input  logic [ADDR_WIDTH-1:0]        delay_samples,
    input  logic [FB_WIDTH-1:0]          feedback_amount,
    input  logic [7:0]                   effect_amount,
    input  logic [1:0]                   mode,
    input  logic                         freeze,
    output logic                         overrun
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int WORDS  = NUM_CH * DEPTH;
    localparam int RAM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CH_W   = $clog2(NUM_CH + 1);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_WRITE, S_OUT} state_t;

    state_t                       r_state;
    logic                         r_ready;
    logic                         r_out_valid;
    logic                         r_overrun;
    logic                         r_delay_load;
    logic [NUM_CH*DATA_WIDTH-1:0] r_audio_out;
    logic [ADDR_WIDTH-1:0]        r_wr_ptr;
    logic [ADDR_WIDTH-1:0]        r_cur_delay;
    logic [RAM_AW-1:0]            r_clr_addr;
    logic [CH_W-1:0]              r_cnt;
    logic signed [DATA_WIDTH-1:0] r_in      [NUM_CH];
    logic signed [DATA_WIDTH-1:0] r_delayed [NUM_CH];
    logic [FB_WIDTH-1:0]          r_fb;
    logic [7:0]                   r_eff;
    logic [1:0]                   r_mode;
    logic                         r_freeze;
    logic signed [DATA_WIDTH-1:0] r_mem [WORDS];
    logic signed [DATA_WIDTH-1:0] r_rdata;

    logic [ADDR_WIDTH-1:0]        w_rd_off;
    logic [ADDR_WIDTH-1:0]        w_target;
    logic [CH_W-1:0]              w_rd_ch;
    logic [RAM_AW-1:0]            w_raddr;
    logic [RAM_AW-1:0]            w_waddr;
    logic                         w_we;
    logic signed [DATA_WIDTH-1:0] w_wdata;
    logic signed [DATA_WIDTH-1:0] w_wval [NUM_CH];
    logic signed [DATA_WIDTH-1:0] w_out  [NUM_CH];

    // Tap offset wraps naturally in ADDR_WIDTH bits, giving modulo-DEPTH addressing.
    assign w_rd_off = r_wr_ptr - r_cur_delay;
    assign w_rd_ch  = (r_cnt < CH_W'(NUM_CH)) ? r_cnt : '0;
    assign w_raddr  = (RAM_AW'(w_rd_ch) << ADDR_WIDTH) | RAM_AW'(w_rd_off);
    assign w_target = (delay_samples == '0) ? ADDR_WIDTH'(1) : delay_samples;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_addr;
        w_wdata = '0;
        if (r_state == S_CLEAR) begin
            w_we = 1'b1;
        end else if (r_state == S_WRITE) begin
            w_we    = 1'b1;
            w_waddr = (RAM_AW'(r_cnt) << ADDR_WIDTH) | RAM_AW'(r_wr_ptr);
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_cnt == CH_W'(c)) w_wdata = w_wval[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_rdata <= r_mem[w_raddr];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic signed [DATA_WIDTH-1:0]          w_in;
            logic signed [DATA_WIDTH-1:0]          w_x;
            logic signed [DATA_WIDTH+FB_WIDTH:0]   w_prod;
            logic signed [DATA_WIDTH+1:0]          w_sum;
            logic signed [DATA_WIDTH-1:0]          w_sat;
            logic signed [DATA_WIDTH+8:0]          w_mix;

            assign w_in   = r_in[gi];
            // Ping-pong feeds each channel from its neighbour's tap.
            assign w_x    = (r_mode == 2'b10) ? r_delayed[(gi + 1) % NUM_CH] : r_delayed[gi];
            assign w_prod = w_x * $signed({1'b0, r_fb});
            assign w_sum  = (DATA_WIDTH+2)'(w_in) + (DATA_WIDTH+2)'(w_prod >>> FB_WIDTH);

            always_comb begin
                if (w_sum[DATA_WIDTH+1:DATA_WIDTH-1] == '0 || w_sum[DATA_WIDTH+1:DATA_WIDTH-1] == '1)
                    w_sat = w_sum[DATA_WIDTH-1:0];
                else if (w_sum[DATA_WIDTH+1])
                    w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                else
                    w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end

            assign w_wval[gi] = r_freeze          ? r_delayed[gi] :
                                (r_mode == 2'b00) ? w_in : w_sat;

            assign w_mix     = w_in * $signed({1'b0, 8'd255 - r_eff})
                             + r_delayed[gi] * $signed({1'b0, r_eff});
            assign w_out[gi] = DATA_WIDTH'(w_mix >>> 8);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_CLEAR;
            r_ready      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
            r_delay_load <= 1'b1;
            r_audio_out  <= '0;
            r_wr_ptr     <= '0;
            r_cur_delay  <= ADDR_WIDTH'(1);
            r_clr_addr   <= '0;
            r_cnt        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (sample_valid && r_state != S_IDLE) r_overrun <= 1'b1;

            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == RAM_AW'(WORDS - 1)) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (sample_valid) begin
                        for (int c = 0; c < NUM_CH; c++)
                            r_in[c] <= audio_in[c*DATA_WIDTH +: DATA_WIDTH];
                        r_fb     <= feedback_amount;
                        r_eff    <= effect_amount;
                        r_mode   <= mode;
                        r_freeze <= freeze;
                        // Glide one sample per frame so delay changes do not jump the tap.
                        if (r_delay_load) begin
                            r_cur_delay  <= w_target;
                            r_delay_load <= 1'b0;
                        end else if (r_cur_delay < w_target) begin
                            r_cur_delay <= r_cur_delay + 1'b1;
                        end else if (r_cur_delay > w_target) begin
                            r_cur_delay <= r_cur_delay - 1'b1;
                        end
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    for (int c = 0; c < NUM_CH; c++)
                        if (r_cnt == CH_W'(c + 1)) r_delayed[c] <= r_rdata;
                    if (r_cnt == CH_W'(NUM_CH)) begin
                        r_cnt   <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_cnt == CH_W'(NUM_CH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    for (int c = 0; c < NUM_CH; c++)
                        r_audio_out[c*DATA_WIDTH +: DATA_WIDTH] <= w_out[c];
                    r_out_valid <= 1'b1;
                    r_wr_ptr    <= r_wr_ptr + 1'b1;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign ready           = r_ready;
    assign audio_out       = r_audio_out;
    assign audio_out_valid = r_out_valid;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_multichannel_delay_engine.sv
// Directed bench for multichannel_delay_engine with a 16-deep, 2-channel, 16-bit configuration.
module tb_multichannel_delay_engine;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int FBW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sample_valid = 1'b0;
    logic [NCH*DW-1:0] audio_in = '0;
    logic              ready;
    logic [NCH*DW-1:0] audio_out;
    logic              audio_out_valid;
    logic [AW-1:0]     delay_samples = AW'(1);
    logic [FBW-1:0]    feedback_amount = '0;
    logic [7:0]        effect_amount = 8'd255;
    logic [1:0]        mode = 2'b00;
    logic              freeze = 1'b0;
    logic              overrun;

    int n_tests = 0;
    int n_fail  = 0;

    multichannel_delay_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH), .FB_WIDTH(FBW)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .audio_in(audio_in),
        .ready(ready), .audio_out(audio_out), .audio_out_valid(audio_out_valid),
        .delay_samples(delay_samples), .feedback_amount(feedback_amount),
        .effect_amount(effect_amount), .mode(mode), .freeze(freeze), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic do_reset(output int lo);
        reset = 1'b1;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        lo = 0;
        do begin
            @(posedge clk); #1;
            lo++;
        end while (!ready && lo < 100);
    endtask

    task automatic send_frame(input int in0, input int in1, output int o0, output int o1, output int lat);
        int w = 0;
        while (!ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: ready=%0b required 1", ready);
        end
        @(negedge clk);
        audio_in = {DW'(in1), DW'(in0)};
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!audio_out_valid && lat < 50);
        n_tests++;
        if (audio_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_valid_timeout: audio_out_valid=%0b required 1", audio_out_valid);
        end
        o0 = int'($signed(audio_out[DW-1:0]));
        o1 = int'($signed(audio_out[2*DW-1:DW]));
        $display("[TB] frame in=(%0d,%0d) out=(%0d,%0d) latency=%0d", in0, in1, o0, o1, lat);
    endtask

    task automatic test_reset();
        int lo;
        reset = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ready !== 1'b0 || audio_out_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%0b valid=%0b overrun=%0b required 0,0,0",
                     ready, audio_out_valid, overrun);
        end
        n_tests++;
        if (audio_out !== '0) begin
            n_fail++;
            $display("FAIL reset_audio_out: got %h required 0", audio_out);
        end
        @(negedge clk);
        reset = 1'b0;
        lo = 0;
        do begin
            @(posedge clk); #1;
            lo++;
        end while (!ready && lo < 100);
        n_tests++;
        if (lo !== 32) begin
            n_fail++;
            $display("FAIL clear_length: ready low for %0d cycles required 32", lo);
        end
        n_tests++;
        if (audio_out !== '0 || overrun !== 1'b0 || audio_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_clear_outputs: out=%h overrun=%0b valid=%0b required 0,0,0",
                     audio_out, overrun, audio_out_valid);
        end
        $display("[TB] reset: ready after %0d cycles", lo);
    endtask

    task automatic test_feedforward();
        int lo, o0, o1, lat;
        int exp0 [6] = '{0, 0, 0, 996, 0, 0};
        do_reset(lo);
        mode = 2'b00; delay_samples = AW'(3); feedback_amount = '0;
        effect_amount = 8'd255; freeze = 1'b0;
        for (int f = 0; f < 6; f++) begin
            send_frame((f == 0) ? 1000 : 0, 0, o0, o1, lat);
            if (f == 0) begin
                n_tests++;
                if (lat !== 6) begin
                    n_fail++;
                    $display("FAIL ff_latency: got %0d cycles required 6", lat);
                end
            end
            n_tests++;
            if (o0 !== exp0[f] || o1 !== 0) begin
                n_fail++;
                $display("FAIL ff_frame%0d: got (%0d,%0d) required (%0d,0)", f, o0, o1, exp0[f]);
            end
        end
    endtask

    task automatic test_feedback();
        int lo, o0, o1, lat;
        int exp0 [8] = '{0, 0, 8160, 0, 4080, 0, 2040, 0};
        do_reset(lo);
        mode = 2'b01; delay_samples = AW'(2); feedback_amount = 8'd128;
        effect_amount = 8'd255; freeze = 1'b0;
        for (int f = 0; f < 8; f++) begin
            send_frame((f == 0) ? 8192 : 0, 0, o0, o1, lat);
            n_tests++;
            if (o0 !== exp0[f] || o1 !== 0) begin
                n_fail++;
                $display("FAIL fb_frame%0d: got (%0d,%0d) required (%0d,0)", f, o0, o1, exp0[f]);
            end
        end
    endtask

    task automatic test_pingpong();
        int lo, o0, o1, lat, in0;
        int exp0 [9] = '{0, 0, 16320, 0, 0, 0, 32639, 0, 0};
        int exp1 [9] = '{0, 0, 0, 0, 16256, 0, 0, 0, 32511};
        do_reset(lo);
        mode = 2'b10; delay_samples = AW'(2); feedback_amount = 8'd255;
        effect_amount = 8'd255; freeze = 1'b0;
        for (int f = 0; f < 9; f++) begin
            in0 = (f == 0) ? 16384 : (f == 4) ? 32767 : 0;
            send_frame(in0, 0, o0, o1, lat);
            n_tests++;
            if (o0 !== exp0[f] || o1 !== exp1[f]) begin
                n_fail++;
                $display("FAIL pp_frame%0d: got (%0d,%0d) required (%0d,%0d)",
                         f, o0, o1, exp0[f], exp1[f]);
            end
        end
    endtask

    task automatic test_dry_mix_negative();
        int lo, o0, o1, lat;
        int exp0 [3] = '{-997, -997, -999};
        int exp1 [3] = '{-32640, -32640, -16384};
        do_reset(lo);
        mode = 2'b11; delay_samples = AW'(1); feedback_amount = 8'd255; freeze = 1'b0;
        for (int f = 0; f < 3; f++) begin
            effect_amount = (f == 2) ? 8'd128 : 8'd0;
            send_frame((f == 2) ? 0 : -1000, (f == 2) ? 0 : -32768, o0, o1, lat);
            n_tests++;
            if (o0 !== exp0[f] || o1 !== exp1[f]) begin
                n_fail++;
                $display("FAIL mix_frame%0d: got (%0d,%0d) required (%0d,%0d)",
                         f, o0, o1, exp0[f], exp1[f]);
            end
        end
    endtask

    task automatic test_overrun();
        int lo, o0, o1, lat, cyc, pulses, first;
        do_reset(lo);
        mode = 2'b00; delay_samples = AW'(1); effect_amount = 8'd255; freeze = 1'b0;
        pulses = 0; first = -1;
        @(negedge clk);
        audio_in = {16'sd5, 16'sd7};
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        if (audio_out_valid) begin pulses++; first = 1; end
        @(negedge clk);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        if (audio_out_valid) begin pulses++; if (first < 0) first = 2; end
        for (cyc = 3; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (audio_out_valid) begin
                pulses++;
                if (first < 0) first = cyc;
            end
        end
        $display("[TB] overrun: pulses=%0d first=%0d overrun=%0b", pulses, first, overrun);
        n_tests++;
        if (pulses !== 1 || first !== 6) begin
            n_fail++;
            $display("FAIL ovr_pulses: got %0d pulses first at %0d required 1 at 6", pulses, first);
        end
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_flag: overrun=%0b required 1", overrun);
        end
        send_frame(0, 0, o0, o1, lat);
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: overrun=%0b required 1", overrun);
        end
        do_reset(lo);
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_reset_clear: overrun=%0b required 0", overrun);
        end
    endtask

    task automatic test_reset_abort();
        int lo, o0, o1, lat, pulses;
        do_reset(lo);
        mode = 2'b00; delay_samples = AW'(1); effect_amount = 8'd255; freeze = 1'b0;
        pulses = 0;
        @(negedge clk);
        audio_in = {16'sd100, 16'sd200};
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (audio_out_valid) pulses++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (audio_out_valid) pulses++;
        end
        @(negedge clk);
        reset = 1'b0;
        lo = 0;
        do begin
            @(posedge clk); #1;
            lo++;
            if (audio_out_valid) pulses++;
        end while (!ready && lo < 100);
        $display("[TB] reset_abort: pulses=%0d clear_cycles=%0d", pulses, lo);
        n_tests++;
        if (pulses !== 0 || lo !== 32) begin
            n_fail++;
            $display("FAIL abort: got %0d pulses, %0d clear cycles required 0 and 32", pulses, lo);
        end
        send_frame(300, 400, o0, o1, lat);
        n_tests++;
        if (lat !== 6 || o0 !== 0 || o1 !== 0) begin
            n_fail++;
            $display("FAIL abort_next_frame: got lat=%0d out=(%0d,%0d) required 6,(0,0)", lat, o0, o1);
        end
    endtask

    task automatic test_delay_ramp();
        int lo, o0, o1, lat;
        int exp0 [10] = '{0, 0, 0, 99, 199, 298, 298, 298, 298, 398};
        do_reset(lo);
        mode = 2'b00; feedback_amount = '0; effect_amount = 8'd255; freeze = 1'b0;
        for (int f = 0; f < 10; f++) begin
            delay_samples = (f < 6) ? AW'(3) : AW'(6);
            send_frame(100 * (f + 1), 0, o0, o1, lat);
            n_tests++;
            if (o0 !== exp0[f] || o1 !== 0) begin
                n_fail++;
                $display("FAIL ramp_frame%0d: got (%0d,%0d) required (%0d,0)", f, o0, o1, exp0[f]);
            end
        end
    endtask

    task automatic test_freeze();
        int lo, o0, o1, lat, r0, r1;
        int wet0 [4] = '{996, 1992, 2988, 3984};
        int wet1 [4] = '{-499, -997, -1495, -1993};
        do_reset(lo);
        mode = 2'b01; delay_samples = AW'(4); feedback_amount = 8'd128;
        effect_amount = 8'd255; freeze = 1'b0;
        for (int f = 0; f < 4; f++) begin
            send_frame(1000 * (f + 1), -500 * (f + 1), o0, o1, lat);
            n_tests++;
            if (o0 !== 0 || o1 !== 0) begin
                n_fail++;
                $display("FAIL freeze_fill%0d: got (%0d,%0d) required (0,0)", f, o0, o1);
            end
        end
        freeze = 1'b1;
        for (int f = 4; f < 12; f++) begin
            r0 = int'($urandom_range(0, 20000)) - 10000;
            r1 = int'($urandom_range(0, 20000)) - 10000;
            send_frame(r0, r1, o0, o1, lat);
            n_tests++;
            if (o0 !== wet0[f % 4] || o1 !== wet1[f % 4]) begin
                n_fail++;
                $display("FAIL freeze_frame%0d: got (%0d,%0d) required (%0d,%0d)",
                         f, o0, o1, wet0[f % 4], wet1[f % 4]);
            end
        end
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_feedforward();
        test_feedback();
        test_pingpong();
        test_dry_mix_negative();
        test_overrun();
        test_reset_abort();
        test_delay_ramp();
        test_freeze();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
